// File: rtl/mem_dma_master_if.sv
// -----------------------------------------------------------------------------
// mem_dma_master_if
// Purpose : bundles the data-memory/IO port that the DMA master shares with the
//           pipeline through the m_req/m_gnt arbiter handshake.
// Signals : m_req     - port request, master -> arbiter
//           m_gnt     - port grant, arbiter -> master
//           m_addr    - byte address (addr[7]=1 selects IO registers)
//           m_datain  - write data, master -> memory/IO
//           m_we      - write enable, one cycle per written word
//           m_dataout - read data, memory/IO -> master
// Modports: master (DMA side), slave (memory/arbiter side)
// -----------------------------------------------------------------------------
interface mem_dma_master_if;
    logic        m_req;
    logic        m_gnt;
    logic [31:0] m_addr;
    logic [31:0] m_datain;
    logic        m_we;
    logic [31:0] m_dataout;

    modport master (
        output m_req,
        output m_addr,
        output m_datain,
        output m_we,
        input  m_gnt,
        input  m_dataout
    );

    modport slave (
        input  m_req,
        input  m_addr,
        input  m_datain,
        input  m_we,
        output m_gnt,
        output m_dataout
    );
endinterface

// File: rtl/mem_dma_master.sv
// -----------------------------------------------------------------------------
// mem_dma_master
// Purpose : word-copy DMA initiator on the memory-stage data port. Copies
//           count_i words from src_addr_i to dst_addr_i (RAM or IO, selected by
//           address bit 7) in ascending order, one RD/WAIT/WR sequence per word.
// Ports   : clock_i, reset_i      - clock, synchronous active-high reset
//           start_i               - launch request, sampled only in IDLE
//           src_addr_i/dst_addr_i - word-aligned byte addresses
//           count_i               - number of words (0 = immediate done)
//           busy_o/done_o/err_o   - status; done_o and err_o are 1-cycle pulses
//           bus                   - mem_dma_master_if.master port
//           fill_mode_i/fill_value_i - only when DMA_FILL_EN is defined
// Config  : DMA_FILL_EN - when defined, fill_mode_i=1 writes fill_value_i to
//           every destination word at one word per cycle, with no reads and no
//           source alignment check.
// -----------------------------------------------------------------------------
module mem_dma_master #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 6
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [CNT_W-1:0] count_i,
`ifdef DMA_FILL_EN
    input  logic             fill_mode_i,
    input  logic [31:0]      fill_value_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    mem_dma_master_if.master bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [CNT_W-1:0] rem_q;
    logic [1:0]       lat_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             req_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
`ifdef DMA_FILL_EN
    logic             fill_q;
`endif

    logic [31:0]      src_inc_d;
    logic [31:0]      dst_inc_d;
    logic [CNT_W-1:0] rem_dec_d;
    logic             fill_start_d;
    logic             fill_act_d;
    logic [31:0]      fill_value_d;
    logic             misalign_d;

    // Address/count arithmetic and start qualification (addresses wrap mod 2**32)
    always_comb begin
        src_inc_d = src_q + 32'd4;
        dst_inc_d = dst_q + 32'd4;
        rem_dec_d = rem_q - CNT_ONE;
`ifdef DMA_FILL_EN
        fill_start_d = fill_mode_i;
        fill_act_d   = fill_q;
        fill_value_d = fill_value_i;
`else
        fill_start_d = 1'b0;
        fill_act_d   = 1'b0;
        fill_value_d = 32'd0;
`endif
        // In fill mode the source address is never used, so only dst must be aligned
        if (fill_start_d) begin
            misalign_d = (dst_addr_i[1:0] != 2'b00);
        end else begin
            misalign_d = ((src_addr_i[1:0] | dst_addr_i[1:0]) != 2'b00);
        end
    end

    // Transfer FSM with registered status and bus outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            src_q   <= 32'd0;
            dst_q   <= 32'd0;
            rem_q   <= CNT_ZERO;
            lat_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
`ifdef DMA_FILL_EN
            fill_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (misalign_d) begin
                            err_q <= 1'b1;
                        end else if (count_i == CNT_ZERO) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            src_q  <= src_addr_i;
                            dst_q  <= dst_addr_i;
                            rem_q  <= count_i;
                            busy_q <= 1'b1;
                            req_q  <= 1'b1;
`ifdef DMA_FILL_EN
                            fill_q <= fill_mode_i;
`endif
                            if (fill_start_d) begin
                                state_q <= ST_WR;
                                addr_q  <= dst_addr_i;
                                wdata_q <= fill_value_d;
                                we_q    <= 1'b1;
                            end else begin
                                state_q <= ST_RD;
                                addr_q  <= src_addr_i;
                                we_q    <= 1'b0;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (bus.m_gnt) begin
                        state_q <= ST_WAIT;
                        lat_q   <= 2'd0;
                    end
                end
                ST_WAIT: begin
                    // Only granted cycles advance the read latency count
                    if (bus.m_gnt) begin
                        if (lat_q == LAT_LAST) begin
                            wdata_q <= bus.m_dataout;
                            addr_q  <= dst_q;
                            we_q    <= 1'b1;
                            state_q <= ST_WR;
                        end else begin
                            lat_q <= lat_q + 2'd1;
                        end
                    end
                end
                ST_WR: begin
                    if (bus.m_gnt) begin
                        src_q <= src_inc_d;
                        dst_q <= dst_inc_d;
                        rem_q <= rem_dec_d;
                        if (rem_dec_d == CNT_ZERO) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                        end else if (fill_act_d) begin
                            addr_q <= dst_inc_d;
                        end else begin
                            state_q <= ST_RD;
                            we_q    <= 1'b0;
                            addr_q  <= src_inc_d;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign bus.m_req    = req_q;
    assign bus.m_addr   = addr_q;
    assign bus.m_datain = wdata_q;
    // Write strobe is qualified by the live grant so a withdrawn grant blocks the write that cycle
    assign bus.m_we     = we_q & bus.m_gnt;

endmodule

// File: tb/tb_mem_dma_master.sv
module tb_mem_dma_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] src = 32'd0;
    logic [31:0] dst = 32'd0;
    logic [5:0]  cnt = 6'd0;
    logic        busy;
    logic        done;
    logic        err;
    logic        gnt = 1'b1;
`ifdef DMA_FILL_EN
    logic        fill_mode = 1'b0;
    logic [31:0] fill_value = 32'd0;
`endif

    int checks = 0;
    int errors = 0;

    // bench-side memory, IO and monitors
    logic [31:0] ram [0:31];
    logic [31:0] out_port0;
    logic [31:0] rd_q = 32'd0;
    logic        poke_en = 1'b0;
    logic [4:0]  poke_idx = 5'd0;
    logic [31:0] poke_val = 32'd0;
    int we_cnt = 0;
    int viol = 0;
    int done_cnt = 0;
    int req_cnt = 0;

    always #5 clk = ~clk;

    mem_dma_master_if bus ();

    assign bus.m_gnt     = gnt;
    assign bus.m_dataout = rd_q;

    mem_dma_master #(.RD_LAT(1), .CNT_W(6)) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .start_i    (start),
        .src_addr_i (src),
        .dst_addr_i (dst),
        .count_i    (cnt),
`ifdef DMA_FILL_EN
        .fill_mode_i  (fill_mode),
        .fill_value_i (fill_value),
`endif
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .bus        (bus)
    );

    function automatic logic [31:0] io_rd(input logic [1:0] sel);
        io_rd = (sel == 2'd0) ? 32'hA5A5_0001 : 32'hA5A5_0002;
    endfunction

    always @(posedge clk) begin
        rd_q <= bus.m_addr[7] ? io_rd(bus.m_addr[3:2]) : ram[bus.m_addr[6:2]];
        if (bus.m_we) begin
            if (bus.m_addr[7]) out_port0 <= bus.m_datain;
            else ram[bus.m_addr[6:2]] <= bus.m_datain;
            we_cnt <= we_cnt + 1;
        end
        if (poke_en) ram[poke_idx] <= poke_val;
        if (bus.m_we && !bus.m_gnt) viol <= viol + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (bus.m_req) req_cnt <= req_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic poke(input int idx, input logic [31:0] val);
        @(negedge clk);
        poke_en = 1'b1; poke_idx = idx[4:0]; poke_val = val;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic run_start(input logic [31:0] s, input logic [31:0] d, input logic [5:0] c);
        @(negedge clk);
        src = s; dst = d; cnt = c; start = 1'b1;
`ifdef DMA_FILL_EN
        fill_mode = 1'b0;
`endif
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // first negedge examined is cycle k0 after the start edge
    task automatic wait_done(input int k0, output int k, output int busy_low, output logic busy_at_done);
        k = -1; busy_low = 0; busy_at_done = 1'b1;
        for (int i = k0; i < k0 + 300; i++) begin
            @(negedge clk);
            if (done) begin
                k = i; busy_at_done = busy;
                break;
            end else if (!busy) begin
                busy_low++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", bus.m_req); end
        checks++; if (bus.m_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", bus.m_we); end
        checks++; if (bus.m_addr !== 32'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.m_addr); end
        checks++; if (bus.m_datain !== 32'd0) begin errors++; $display("FAIL reset_datain: got %h expected 0", bus.m_datain); end
        rst = 1'b0;
    endtask

    task automatic test_copy();
        int k, bl, w0; logic bd;
        for (int i = 0; i < 4; i++) poke(i, 32'(i + 1));
        for (int i = 16; i < 20; i++) poke(i, 32'd0);
        w0 = we_cnt;
        run_start(32'h00, 32'h40, 6'd4);
        wait_done(1, k, bl, bd);
        checks++; if (k !== 13) begin errors++; $display("FAIL copy_done_cycle: got %0d expected 13", k); end
        checks++; if (bl !== 0) begin errors++; $display("FAIL copy_busy_gap: got %0d low cycles expected 0", bl); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL copy_busy_at_done: got %b expected 0", bd); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (ram[16 + i] !== 32'(i + 1)) begin errors++; $display("FAIL copy_data%0d: got %h expected %h", i, ram[16 + i], i + 1); end
        end
        checks++; if (we_cnt - w0 !== 4) begin errors++; $display("FAIL copy_we_count: got %0d expected 4", we_cnt - w0); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL copy_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_io();
        int k, bl; logic bd;
        poke(4, 32'd0);
        run_start(32'h80, 32'h10, 6'd1);
        wait_done(1, k, bl, bd);
        checks++; if (k !== 4) begin errors++; $display("FAIL io_rd_done_cycle: got %0d expected 4", k); end
        checks++; if (ram[4] !== 32'hA5A5_0001) begin errors++; $display("FAIL io_rd_data: got %h expected a5a50001", ram[4]); end
        poke(5, 32'h1234_5678);
        run_start(32'h14, 32'h80, 6'd1);
        wait_done(1, k, bl, bd);
        checks++; if (out_port0 !== 32'h1234_5678) begin errors++; $display("FAIL io_wr_data: got %h expected 12345678", out_port0); end
    endtask

    task automatic test_grant_stall();
        int kd, stall_bad, w0;
        poke(24, 32'd0); poke(25, 32'd0);
        w0 = we_cnt; kd = -1; stall_bad = 0;
        run_start(32'h00, 32'h60, 6'd2);
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (k >= 4 && k <= 7) begin
                if (bus.m_we !== 1'b0 || bus.m_addr !== 32'h60) stall_bad++;
            end
            if (k == 3) gnt = 1'b0;
            if (k == 8) gnt = 1'b1;
            if (done) begin kd = k; break; end
        end
        gnt = 1'b1;
        checks++; if (kd !== 12) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 12", kd); end
        checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", stall_bad); end
        checks++; if (ram[24] !== 32'd1 || ram[25] !== 32'd2) begin errors++; $display("FAIL stall_data: got %h %h expected 1 2", ram[24], ram[25]); end
        checks++; if (we_cnt - w0 !== 2) begin errors++; $display("FAIL stall_we_count: got %0d expected 2", we_cnt - w0); end
    endtask

    task automatic test_edges();
        int k, bl, w0, d0, r0; logic bd;
        // count = 0
        w0 = we_cnt;
        run_start(32'h00, 32'h40, 6'd0);
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b expected 1 0", done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
        checks++; if (we_cnt - w0 !== 0) begin errors++; $display("FAIL zero_we: got %0d expected 0", we_cnt - w0); end
        // misaligned source
        w0 = we_cnt; d0 = done_cnt; r0 = req_cnt;
        run_start(32'h02, 32'h40, 6'd4);
        @(negedge clk);
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL misalign_err: got err=%b busy=%b expected 1 0", err, busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL misalign_err_pulse: got %b expected 0", err); end
        repeat (5) @(negedge clk);
        checks++; if (req_cnt - r0 !== 0 || we_cnt - w0 !== 0 || done_cnt - d0 !== 0) begin
            errors++; $display("FAIL misalign_no_access: got req=%0d we=%0d done=%0d expected 0 0 0", req_cnt - r0, we_cnt - w0, done_cnt - d0);
        end
        // misaligned destination
        run_start(32'h00, 32'h41, 6'd1);
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL misalign_dst_err: got %b expected 1", err); end
        // start while busy
        poke(28, 32'd0); poke(15, 32'd0);
        w0 = we_cnt; d0 = done_cnt;
        run_start(32'h08, 32'h3C, 6'd1);
        @(negedge clk);
        src = 32'h00; dst = 32'h70; cnt = 6'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(2, k, bl, bd);
        checks++; if (k !== 4) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 4", k); end
        repeat (8) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL busy_start_done_cnt: got %0d expected 1", done_cnt - d0); end
        checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL busy_start_we: got %0d expected 1", we_cnt - w0); end
        checks++; if (ram[28] !== 32'd0 || ram[15] !== 32'd3) begin errors++; $display("FAIL busy_start_data: got %h %h expected 0 3", ram[28], ram[15]); end
    endtask

    task automatic test_reset_mid();
        int k, bl, w0, d0; logic bd;
        for (int i = 20; i < 23; i++) poke(i, 32'd0);
        w0 = we_cnt; d0 = done_cnt;
        run_start(32'h00, 32'h50, 6'd3);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || bus.m_we !== 1'b0 || bus.m_req !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got busy=%b we=%b req=%b expected 0 0 0", busy, bus.m_we, bus.m_req);
        end
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", done_cnt - d0); end
        checks++; if (we_cnt - w0 !== 1) begin errors++; $display("FAIL abort_we: got %0d expected 1", we_cnt - w0); end
        checks++; if (ram[20] !== 32'd1 || ram[21] !== 32'd0) begin errors++; $display("FAIL abort_data: got %h %h expected 1 0", ram[20], ram[21]); end
        run_start(32'h04, 32'h50, 6'd2);
        wait_done(1, k, bl, bd);
        checks++; if (k !== 7) begin errors++; $display("FAIL restart_done_cycle: got %0d expected 7", k); end
        checks++; if (ram[20] !== 32'd2 || ram[21] !== 32'd3) begin errors++; $display("FAIL restart_data: got %h %h expected 2 3", ram[20], ram[21]); end
    endtask

`ifdef DMA_FILL_EN
    task automatic test_fill();
        int k, bl, w0; logic bd;
        for (int i = 8; i < 11; i++) poke(i, 32'd0);
        w0 = we_cnt;
        @(negedge clk);
        src = 32'h02; dst = 32'h20; cnt = 6'd3; fill_mode = 1'b1; fill_value = 32'hDEAD_BEEF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(1, k, bl, bd);
        fill_mode = 1'b0;
        checks++; if (k !== 4) begin errors++; $display("FAIL fill_done_cycle: got %0d expected 4", k); end
        checks++; if (we_cnt - w0 !== 3) begin errors++; $display("FAIL fill_we: got %0d expected 3", we_cnt - w0); end
        for (int i = 8; i < 11; i++) begin
            checks++; if (ram[i] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fill_data%0d: got %h expected deadbeef", i, ram[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_copy();
        test_io();
        test_grant_stall();
        test_edges();
        test_reset_mid();
`ifdef DMA_FILL_EN
        test_fill();
`endif
        checks++; if (viol !== 0) begin errors++; $display("FAIL we_without_gnt: got %0d cycles expected 0", viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
